// File: rtl/cotm32_pkg.sv
// Shared types for the cotm32 pipeline control path: sequencer states, PC source
// select and the per-stage stall/flush strobe bundle.
package cotm32_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_MEM_WAIT,
    CTRL_MDU_WAIT,
    CTRL_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_SEL_SEQ,
    PC_SEL_BRANCH,
    PC_SEL_TRAP,
    PC_SEL_MRET
  } pc_sel_t;

  typedef struct packed {
    logic stall_if;
    logic stall_ex;
    logic stall_mem;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
  } strobes_t;

  // A stage that is held must keep its contents, so a stall masks the flush of that stage.
  function automatic strobes_t resolve_strobes(input strobes_t s);
    strobes_t r;
    r             = s;
    r.flush_ifid  = s.flush_ifid  & ~s.stall_if;
    r.flush_idex  = s.flush_idex  & ~s.stall_ex;
    r.flush_exmem = s.flush_exmem & ~s.stall_mem;
    return r;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/strobe bundle between the pipeline sequencer and the stage logic around it.
interface pipeline_ctrl_if;
  import cotm32_pkg::*;

  logic    i_hz_stall_ifid;
  logic    i_hz_flush_ifid;
  logic    i_hz_flush_idex;
  logic    i_ex_take_branch;
  logic    i_mem_req;
  logic    i_mem_ready;
  logic    i_mdu_start;
  logic    i_mdu_done;
  logic    i_trap;
  logic    i_mret;
  logic    o_stall_if;
  logic    o_stall_ex;
  logic    o_stall_mem;
  logic    o_flush_ifid;
  logic    o_flush_idex;
  logic    o_flush_exmem;
  pc_sel_t o_pc_sel;
  logic    o_mem_timeout;
  logic    o_busy;

  modport slave (
    input  i_hz_stall_ifid, i_hz_flush_ifid, i_hz_flush_idex, i_ex_take_branch,
           i_mem_req, i_mem_ready, i_mdu_start, i_mdu_done, i_trap, i_mret,
    output o_stall_if, o_stall_ex, o_stall_mem, o_flush_ifid, o_flush_idex,
           o_flush_exmem, o_pc_sel, o_mem_timeout, o_busy
  );

  modport master (
    output i_hz_stall_ifid, i_hz_flush_ifid, i_hz_flush_idex, i_ex_take_branch,
           i_mem_req, i_mem_ready, i_mdu_start, i_mdu_done, i_trap, i_mret,
    input  o_stall_if, o_stall_ex, o_stall_mem, o_flush_ifid, o_flush_idex,
           o_flush_exmem, o_pc_sel, o_mem_timeout, o_busy
  );

endinterface

// File: rtl/pipeline_ctrl_wait_timer.sv
// Saturating cycle counter with synchronous clear; o_expired flags the last
// cycle of a LIMIT-cycle window.
module wait_timer #(
  parameter int unsigned LIMIT = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (i_clear)                      count_d = '0;
    else if (i_en && count_q != LAST) count_d = count_q + CNT_W'(1);
  end

  assign o_expired = (count_q == LAST);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges hazard strobes with memory/MDU wait states, trap
// entry and a memory-wait watchdog into per-stage stall/flush and a PC select.
module pipeline_ctrl
  import cotm32_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 256
) (
  input logic              i_clk,
  input logic              i_rst_n,
  pipeline_ctrl_if.slave   bus
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  strobes_t    strb;
  strobes_t    strb_res;
  pc_sel_t     pc_sel;
  logic        mem_timeout;
  logic        timer_expired;
  logic        in_mem_wait;

  assign in_mem_wait = (state_q == CTRL_MEM_WAIT);

  // Watchdog restarts from zero on each entry into MEM_WAIT.
  wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (!in_mem_wait),
    .i_en      (in_mem_wait),
    .o_expired (timer_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= CTRL_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    strb        = '0;
    pc_sel      = PC_SEL_SEQ;
    mem_timeout = 1'b0;
    case (state_q)
      CTRL_RUN: begin
        if (bus.i_trap) begin
          state_d = CTRL_TRAP;
        end else if (bus.i_mret) begin
          pc_sel           = PC_SEL_MRET;
          strb.flush_ifid  = 1'b1;
          strb.flush_idex  = 1'b1;
          strb.flush_exmem = 1'b1;
        end else if (bus.i_mem_req && !bus.i_mem_ready) begin
          strb.stall_if  = 1'b1;
          strb.stall_ex  = 1'b1;
          strb.stall_mem = 1'b1;
          state_d        = CTRL_MEM_WAIT;
        end else if (bus.i_mdu_start && !bus.i_mdu_done) begin
          strb.stall_if    = 1'b1;
          strb.stall_ex    = 1'b1;
          strb.flush_exmem = 1'b1;
          state_d          = CTRL_MDU_WAIT;
        end else begin
          strb.stall_if   = bus.i_hz_stall_ifid;
          strb.flush_ifid = bus.i_hz_flush_ifid | bus.i_ex_take_branch;
          strb.flush_idex = bus.i_hz_flush_idex | bus.i_ex_take_branch;
          if (bus.i_ex_take_branch) pc_sel = PC_SEL_BRANCH;
        end
      end
      CTRL_MEM_WAIT: begin
        if (bus.i_mem_ready) begin
          state_d = CTRL_RUN;
        end else begin
          strb.stall_if  = 1'b1;
          strb.stall_ex  = 1'b1;
          strb.stall_mem = 1'b1;
          if (timer_expired) begin
            mem_timeout = 1'b1;
            state_d     = CTRL_TRAP;
          end
        end
      end
      CTRL_MDU_WAIT: begin
        if (bus.i_mdu_done) begin
          state_d = CTRL_RUN;
        end else begin
          strb.stall_if    = 1'b1;
          strb.stall_ex    = 1'b1;
          strb.flush_exmem = 1'b1;
        end
      end
      CTRL_TRAP: begin
        pc_sel           = PC_SEL_TRAP;
        strb.flush_ifid  = 1'b1;
        strb.flush_idex  = 1'b1;
        strb.flush_exmem = 1'b1;
        state_d          = CTRL_RUN;
      end
      default: state_d = CTRL_RUN;
    endcase
  end

  assign strb_res = resolve_strobes(strb);

  assign bus.o_stall_if    = strb_res.stall_if;
  assign bus.o_stall_ex    = strb_res.stall_ex;
  assign bus.o_stall_mem   = strb_res.stall_mem;
  assign bus.o_flush_ifid  = strb_res.flush_ifid;
  assign bus.o_flush_idex  = strb_res.flush_idex;
  assign bus.o_flush_exmem = strb_res.flush_exmem;
  assign bus.o_pc_sel      = pc_sel;
  assign bus.o_mem_timeout = mem_timeout;
  assign bus.o_busy        = (state_q != CTRL_RUN);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_ctrl;
  import cotm32_pkg::*;

  localparam int unsigned T = 4;

  // Input vector order: hs hfi hfx br req rdy ms md tr mr
  localparam logic [9:0] IN_HS  = 10'b10_0000_0000;
  localparam logic [9:0] IN_HFI = 10'b01_0000_0000;
  localparam logic [9:0] IN_HFX = 10'b00_1000_0000;
  localparam logic [9:0] IN_BR  = 10'b00_0100_0000;
  localparam logic [9:0] IN_REQ = 10'b00_0010_0000;
  localparam logic [9:0] IN_RDY = 10'b00_0001_0000;
  localparam logic [9:0] IN_MS  = 10'b00_0000_1000;
  localparam logic [9:0] IN_MD  = 10'b00_0000_0100;
  localparam logic [9:0] IN_TR  = 10'b00_0000_0010;
  localparam logic [9:0] IN_MR  = 10'b00_0000_0001;

  // Output vector order: sif sex smem fif fidex fexm pc[1:0] timeout busy
  localparam logic [9:0] O_SIF   = 10'b10_0000_0000;
  localparam logic [9:0] O_SEX   = 10'b01_0000_0000;
  localparam logic [9:0] O_SMEM  = 10'b00_1000_0000;
  localparam logic [9:0] O_FIF   = 10'b00_0100_0000;
  localparam logic [9:0] O_FIDEX = 10'b00_0010_0000;
  localparam logic [9:0] O_FEXM  = 10'b00_0001_0000;
  localparam logic [9:0] O_PC_BR = 10'b00_0000_0100;
  localparam logic [9:0] O_PC_TR = 10'b00_0000_1000;
  localparam logic [9:0] O_PC_MR = 10'b00_0000_1100;
  localparam logic [9:0] O_TO    = 10'b00_0000_0010;
  localparam logic [9:0] O_BUSY  = 10'b00_0000_0001;
  localparam logic [9:0] O_SALL  = O_SIF | O_SEX | O_SMEM;
  localparam logic [9:0] O_FALL  = O_FIF | O_FIDEX | O_FEXM;
  localparam logic [9:0] O_MDU   = O_SIF | O_SEX | O_FEXM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.MEM_TIMEOUT(T)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  function automatic logic [9:0] outs();
    return {bus.o_stall_if, bus.o_stall_ex, bus.o_stall_mem, bus.o_flush_ifid,
            bus.o_flush_idex, bus.o_flush_exmem, bus.o_pc_sel, bus.o_mem_timeout, bus.o_busy};
  endfunction

  task automatic apply(input logic [9:0] v);
    {bus.i_hz_stall_ifid, bus.i_hz_flush_ifid, bus.i_hz_flush_idex, bus.i_ex_take_branch,
     bus.i_mem_req, bus.i_mem_ready, bus.i_mdu_start, bus.i_mdu_done, bus.i_trap, bus.i_mret} = v;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input string name, input logic [9:0] in_v, input logic [9:0] exp);
    @(posedge clk);
    #1 apply(in_v);
    #1 check(name, outs(), exp);
  endtask

  // Behavioural model: tracks wait age / pending trap and derives outputs from the rules.
  initial begin : model
    int          mem_age;
    bit          mdu_wait, trap_next;
    bit          hs, hfi, hfx, br, req, rdy, ms, md, tr, mr;
    bit          sif, sex, smem, fif, fidex, fexm, to, busy;
    logic [1:0]  pc;
    mem_age = -1; mdu_wait = 1'b0; trap_next = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_age = -1; mdu_wait = 1'b0; trap_next = 1'b0;
      end
      {hs, hfi, hfx, br, req, rdy, ms, md, tr, mr} =
        {bus.i_hz_stall_ifid, bus.i_hz_flush_ifid, bus.i_hz_flush_idex, bus.i_ex_take_branch,
         bus.i_mem_req, bus.i_mem_ready, bus.i_mdu_start, bus.i_mdu_done, bus.i_trap, bus.i_mret};
      {sif, sex, smem, fif, fidex, fexm, to} = '0;
      pc   = 2'd0;
      busy = (mem_age >= 0) || mdu_wait || trap_next;
      if (trap_next) begin
        {fif, fidex, fexm} = 3'b111; pc = 2'd2; trap_next = 1'b0;
      end else if (mem_age >= 0) begin
        if (rdy) mem_age = -1;
        else begin
          {sif, sex, smem} = 3'b111;
          if (mem_age == int'(T) - 1) begin
            to = 1'b1; mem_age = -1; trap_next = 1'b1;
          end else mem_age++;
        end
      end else if (mdu_wait) begin
        if (md) mdu_wait = 1'b0;
        else {sif, sex, fexm} = 3'b111;
      end else if (tr) begin
        trap_next = 1'b1;
      end else if (mr) begin
        {fif, fidex, fexm} = 3'b111; pc = 2'd3;
      end else if (req && !rdy) begin
        {sif, sex, smem} = 3'b111; mem_age = 0;
      end else if (ms && !md) begin
        {sif, sex, fexm} = 3'b111; mdu_wait = 1'b1;
      end else begin
        sif = hs; fif = hfi | br; fidex = hfx | br;
        if (br) pc = 2'd1;
      end
      fif   = fif & !sif;
      fidex = fidex & !sex;
      fexm  = fexm & !smem;
      if (!rst_n) begin
        mem_age = -1; mdu_wait = 1'b0; trap_next = 1'b0;
      end
      check("model", outs(), {sif, sex, smem, fif, fidex, fexm, pc, to, busy});
    end
  end

  initial begin : stim
    apply('0);
    rst_n = 1'b0;
    #2 check("reset", outs(), '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("reset_release", outs(), '0);

    step("hazard_pass", IN_HS | IN_HFX, O_SIF | O_FIDEX);
    step("hazard_stall_wins", IN_HS | IN_HFI, O_SIF);
    step("idle", '0, '0);

    step("mem_enter", IN_REQ, O_SALL);
    step("mem_wait0", IN_REQ, O_SALL | O_BUSY);
    step("mem_wait1", IN_REQ, O_SALL | O_BUSY);
    step("mem_ready", IN_REQ | IN_RDY, O_BUSY);
    step("mem_after", '0, '0);
    step("mem_same_cycle_ready", IN_REQ | IN_RDY, '0);

    step("to_enter", IN_REQ, O_SALL);
    for (int i = 0; i < int'(T) - 1; i++) step("to_wait", IN_REQ, O_SALL | O_BUSY);
    step("to_pulse", IN_REQ, O_SALL | O_BUSY | O_TO);
    step("to_trap", IN_REQ, O_FALL | O_PC_TR | O_BUSY);
    step("to_after", '0, '0);

    step("mdu_enter", IN_BR | IN_MS, O_MDU);
    for (int i = 0; i < 4; i++) step("mdu_wait", IN_BR | IN_MS, O_MDU | O_BUSY);
    step("mdu_done", IN_BR | IN_MS | IN_MD, O_BUSY);
    step("mdu_branch", IN_BR, O_FIF | O_FIDEX | O_PC_BR);
    step("idle", '0, '0);

    step("trap_mix", IN_TR | IN_MR | IN_REQ, '0);
    step("trap_cycle", '0, O_FALL | O_PC_TR | O_BUSY);
    step("mret", IN_MR, O_FALL | O_PC_MR);
    step("idle", '0, '0);

    step("rst_enter", IN_REQ, O_SALL);
    step("rst_wait0", IN_REQ, O_SALL | O_BUSY);
    @(posedge clk);
    #1 begin rst_n = 1'b0; apply('0); end
    #1 check("rst_mid", outs(), '0);
    for (int i = 0; i < 3; i++) step("rst_hold", '0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_exit", outs(), '0);
    step("rst_re_enter", IN_REQ, O_SALL);
    for (int i = 0; i < int'(T) - 1; i++) step("rst_re_wait", IN_REQ, O_SALL | O_BUSY);
    step("rst_re_pulse", IN_REQ, O_SALL | O_BUSY | O_TO);
    step("rst_re_trap", '0, O_FALL | O_PC_TR | O_BUSY);

    for (int n = 0; n < 3000; n++) begin
      logic [9:0] v;
      @(posedge clk);
      #1;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 249) == 0) rst_n = 1'b0;
      v = '0;
      if ($urandom_range(0, 3) == 0) v |= IN_HS;
      if ($urandom_range(0, 3) == 0) v |= IN_HFI;
      if ($urandom_range(0, 3) == 0) v |= IN_HFX;
      if ($urandom_range(0, 3) == 0) v |= IN_BR;
      if ($urandom_range(0, 9) < 4)  v |= IN_REQ;
      if ($urandom_range(0, 9) < 3)  v |= IN_RDY;
      if ($urandom_range(0, 9) < 3)  v |= IN_MS;
      if ($urandom_range(0, 9) < 3)  v |= IN_MD;
      if ($urandom_range(0, 19) == 0) v |= IN_TR;
      if ($urandom_range(0, 19) == 0) v |= IN_MR;
      apply(v);
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the cotm32 five-stage core. It sits between the hazard unit, the LSU data-bus handshake, the multi-cycle MDU and the trap logic, and resolves their requests into one consistent set of per-stage stall/flush strobes and a PC-source select. It owns three things: multi-cycle wait states (memory, MDU), trap-entry sequencing and a memory-wait watchdog. It merges single-cycle hazard-unit strobes with these.

## Interface
Parameters:
- MEM_TIMEOUT, default 256: number of consecutive MEM_WAIT cycles before a bus timeout is declared. Legal range is 2..65535. The counter width is $clog2(MEM_TIMEOUT).

Ports:
- i_clk  in  1  core clock; everything is rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_hz_stall_ifid  in  1  load-use stall request from the hazard unit.
- i_hz_flush_ifid  in  1  flush request from the hazard unit.
- i_hz_flush_idex  in  1  flush request from the hazard unit.
- i_ex_take_branch  in  1  the EX-stage branch/jump resolves taken.
- i_mem_req  in  1  the MEM-stage instruction has an outstanding data-bus access.
- i_mem_ready  in  1  the data bus completes the access this cycle.
- i_mdu_start  in  1  a valid MUL/DIV instruction is in EX.
- i_mdu_done  in  1  the MDU result is valid this cycle.
- i_trap  in  1  an exception or interrupt is committed at MEM.
- i_mret  in  1  MRET is committed at MEM.
- o_stall_if  out  1  hold the PC and the IF/ID register.
- o_stall_ex  out  1  hold the ID/EX register.
- o_stall_mem  out  1  hold the EX/MEM register.
- o_flush_ifid  out  1  bubble IF/ID.
- o_flush_idex  out  1  bubble ID/EX.
- o_flush_exmem  out  1  bubble EX/MEM.
- o_pc_sel  out  pc_sel_t  next-PC source.
- o_mem_timeout  out  1  one-cycle pulse indicating a bus-timeout cause for the trap CSR logic.
- o_busy  out  1  the state is not RUN.

## Operation
States and transitions:
- RUN: trap has the highest priority, then i_mret, then memory, then MDU, then the hazard unit.
  - If i_trap, go to TRAP.
  - Else if i_mret, set o_pc_sel=PC_SEL_MRET, flush IF/ID, ID/EX and EX/MEM, and stay in RUN.
  - Else if i_mem_req && !i_mem_ready, assert all stalls and flush_exmem=0, then go to MEM_WAIT.
  - Else if i_mdu_start && !i_mdu_done, assert stall_if, assert stall_ex and flush_exmem (bubble into MEM), then go to MDU_WAIT.
  - Else pass the hazard strobes through: stall_if = i_hz_stall_ifid, flush_ifid = i_hz_flush_ifid | take_branch, flush_idex = i_hz_flush_idex | take_branch. If take_branch, o_pc_sel=PC_SEL_BRANCH.
- MEM_WAIT:
  - Assert stall_if, stall_ex and stall_mem. All hazard, branch, trap and mret inputs are ignored because their stages are frozen.
  - The wait counter increments each cycle.
  - If i_mem_ready, release the stalls combinationally this cycle and go to RUN.
  - Else if the count is MEM_TIMEOUT-1, pulse o_mem_timeout and go to TRAP.
- MDU_WAIT:
  - Assert the same strobes as on entry. The hazard, branch, trap and mret inputs are ignored.
  - If i_mdu_done, release this cycle and go to RUN.
- TRAP: lasts one cycle. Set o_pc_sel=PC_SEL_TRAP, flush IF/ID, ID/EX and EX/MEM, assert no stalls, then go to RUN.

General rules:
- In every state, a flush of a stage is never asserted together with a stall of that same stage. In that case the stall wins.
- Reset has the following effects:
  - state=RUN, counter=0.
  - Outputs with all inputs low: every stall and flush is 0, o_pc_sel=PC_SEL_SEQ, o_mem_timeout=0, o_busy=0.
- Reset asserted mid-wait aborts the wait immediately. No pulse is emitted.

## Timing
- Stall and flush outputs are combinational from (state, inputs), so a wait request stalls in the same cycle it appears. The state and counter are registered.
- The counter clears on every entry to MEM_WAIT. A wait therefore lasts at most MEM_TIMEOUT cycles, and the timeout pulse comes in the last of them.
- If i_mem_ready is high in the timeout cycle, the ready wins: no pulse, and the next state is RUN.
- MRET and branch redirect have zero latency. Trap redirect lands exactly one cycle after i_trap is sampled in RUN.
- i_mem_ready or i_mdu_done arriving in the same cycle as the request produces no stall and no state change.

## Structure
- In cotm32_pkg:
  - ctrl_state_t enum: CTRL_RUN, CTRL_MEM_WAIT, CTRL_MDU_WAIT, CTRL_TRAP.
  - pc_sel_t enum: PC_SEL_SEQ, PC_SEL_BRANCH, PC_SEL_TRAP, PC_SEL_MRET.
- One sub-module, wait_timer: a parameterised saturating cycle counter with clear/enable inputs and an o_expired output. pipeline_ctrl instantiates it for the watchdog.

## Test plan
- Reset with all inputs low: all strobes are 0, o_pc_sel=PC_SEL_SEQ. With i_hz_stall_ifid=1 and i_hz_flush_idex=1: stall_if=1, flush_idex=1, nothing else asserted.
- i_mem_req=1 with ready low for 3 cycles, then high: stall_if, stall_ex and stall_mem are high for 3 cycles and low in the ready cycle. o_busy is high for 3 cycles, and the state is RUN afterwards.
- MEM_TIMEOUT=4, ready never rises: o_mem_timeout pulses in the 4th wait cycle. The next cycle has o_pc_sel=PC_SEL_TRAP with all three flushes, then the state returns to RUN.
- i_mdu_start with done after 5 cycles while i_ex_take_branch=1 throughout: stall_if, stall_ex and flush_exmem are held, with no branch redirect. After release, the branch redirects (o_pc_sel=PC_SEL_BRANCH, flush_ifid=1, flush_idex=1).
- i_trap, i_mret and i_mem_req (ready low) all in the same RUN cycle: TRAP is taken next, with no MEM_WAIT and no PC_SEL_MRET.
- Reset pulse in the middle of MEM_WAIT: state=RUN, counter=0, no timeout pulse, all strobes 0.
